sha256_nonce_sched: RTL and testbench
=====================================

# sha256_nonce_sched

Nonce-range scheduler for a bank of `sha256_double` search cores. It accepts one mining job (start nonce plus count), splits the range into fixed-size chunks and dispatches each chunk to an idle core by pulsing that core's start with a base nonce. It retires chunks on a per-core cycle budget and reports the first in-range winning nonce, or exhaustion of the range. Job payload (data, midstate, target) is fanned out to the cores by a separate path; this block only sequences nonce bases and starts.

## Interface
- NUM_CORES, 4: number of search cores driven.
- CHUNK, 1024: nonces per dispatch. Power of two, at most 2^16.
- CHUNK_CYCLES, 65536: cycles a core is allowed to search one chunk before it counts as expired. Must be at least 2.

- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- job_valid  in  1  job offer.
- job_ready  out  1  high in IDLE; a job is accepted on job_valid && job_ready.
- job_nonce_start  in  32  first nonce of the range.
- job_nonce_count  in  32  number of nonces in the range; 0 means empty.
- abort  in  1  cancels the current job.
- core_start  out  NUM_CORES  one-cycle start pulse per core.
- core_nonce_base  out  NUM_CORES*32  base nonce per core; held stable from the pulse until the next pulse.
- core_found  in  NUM_CORES  level from each core's out_valid.
- core_nonce  in  NUM_CORES*32  each core's out_nonce_found.
- res_valid  out  1  one-cycle result strobe.
- res_found  out  1  1 = nonce found, 0 = range exhausted.
- res_nonce  out  32  winning nonce; 0 when res_found=0.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - job_ready=1.
  - On accept: latch start and count. Set next_base=start and remaining=count (33-bit). Clear all core-active flags. Go to RUN.
- **RUN, dispatch**
  - At most one dispatch per cycle.
  - Target is the lowest-index core that is not active and not blanked.
  - Dispatch only if remaining>0. The dispatch:
    - pulses core_start[i];
    - sets core_nonce_base[i]=next_base;
    - sets next_base += CHUNK (wraps mod 2^32);
    - sets remaining -= min(CHUNK, remaining);
    - loads budget[i]=CHUNK_CYCLES;
    - marks core i active.
- **RUN, budget**
  - Each active core's budget decrements every cycle.
  - When the budget reaches 0, the core becomes inactive (expired) and is eligible for redispatch from the next cycle.
- **Found qualification**
  - core_found[i] counts only if all of the following hold:
    - core i is active;
    - at least 2 cycles have passed since its start pulse (blanking covers the core's stale out_valid);
    - (core_nonce[i] - start) mod 2^32 < count.
  - A found that fails the range check is ignored, and core i is retired as if expired. This covers the tail of a partial final chunk.
- **Priority**
  - abort > qualified found > exhaustion > dispatch.
  - Among simultaneous qualified founds, the lowest core index wins.
  - A found beats a budget expiry on the same cycle for the same core.
- **Qualified found** → latch res_nonce, res_found=1, go to DONE.
- **Exhaustion** (remaining=0 and no core active) → res_found=0, go to DONE.
- **DONE**
  - res_valid=1 for exactly one cycle.
  - Go to IDLE; all active flags cleared.
- **Abort** in RUN or DONE → IDLE next cycle. No res_valid; outstanding strobes are suppressed.
- **count=0**: RUN sees exhaustion immediately. No core is started.

## Timing
- Reset values:
  - job_ready=1.
  - busy=0.
  - core_start=0, core_nonce_base=0.
  - res_valid=0, res_found=0, res_nonce=0.
  - State IDLE; all counters 0.
- Accept at cycle T: core 0 starts at T+1, core k at T+1+k, for as many chunks as exist.
- Expiry to redispatch: budget hits 0 at cycle E; the core's new start pulse is no earlier than E+1.
- Qualified core_found sampled at cycle F: res_valid at F+1, job_ready at F+2.
- Exhaustion with the last core expiring at E: res_valid at E+1.
- count=0 accepted at T: res_valid at T+2 with res_found=0.
- res_nonce and res_found hold their values until the next res_valid or reset.
- Reset asserted mid-job: all outputs return to reset values immediately; no res_valid.

## Test plan
Bench parameters: NUM_CORES=4, CHUNK=16, CHUNK_CYCLES=8.
- Job start=0x100, count=64, no founds → starts at T+1..T+4 with bases 0x100/0x110/0x120/0x130; no redispatch; res_valid with res_found=0 after the last expiry.
- start=0, count=100 → 7 chunks dispatched in total; the 7th base is 0x60; exhaustion is reported only after all 7 chunks expire.
- Cores 1 and 3 assert core_found in the same cycle with nonces 0x15 and 0x31 → res_nonce=0x15 one cycle later.
- start=0xFFFFFFF8, count=32 → bases 0xFFFFFFF8 and 0x00000008; found nonce 0x00000003 is accepted.
- count=20, core 1 (base 0x10) reports 0x1F → out of range, ignored, core retired; range exhausts with res_found=0.
- abort one cycle after accept, and rst_n low during RUN → no res_valid; job_ready=1; a new job is accepted with fresh bases.

Source files
------------

// File: rtl/sha256_nonce_sched.sv
// Nonce-range scheduler: splits one job's nonce range into fixed chunks, dispatches
// them to idle search cores, retires chunks on a cycle budget and reports the result.
module sha256_nonce_sched #(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned CHUNK        = 1024,
    parameter int unsigned CHUNK_CYCLES = 65536
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [31:0]               job_nonce_start_i,
    input  logic [31:0]               job_nonce_count_i,
    input  logic                      abort_i,
    output logic [NUM_CORES-1:0]      core_start_o,
    output logic [NUM_CORES*32-1:0]   core_nonce_base_o,
    input  logic [NUM_CORES-1:0]      core_found_i,
    input  logic [NUM_CORES*32-1:0]   core_nonce_i,
    output logic                      res_valid_o,
    output logic                      res_found_o,
    output logic [31:0]               res_nonce_o,
    output logic                      busy_o
);

    localparam int unsigned BW = $clog2(CHUNK_CYCLES + 1);
    typedef logic [BW-1:0] budget_t;
    localparam budget_t     BUDGET_FULL = budget_t'(CHUNK_CYCLES);
    localparam budget_t     BLANK_LIMIT = budget_t'(CHUNK_CYCLES - 2);
    localparam logic [32:0] CHUNK33     = 33'(CHUNK);
    localparam logic [31:0] CHUNK32     = 32'(CHUNK);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          start_q, start_d, count_q, count_d;
    logic [31:0]          next_base_q, next_base_d;
    logic [32:0]          remaining_q, remaining_d;
    logic [NUM_CORES-1:0] active_q, active_d;
    logic [NUM_CORES-1:0] start_pulse_q, start_pulse_d;
    budget_t              budget_q [NUM_CORES];
    budget_t              budget_d [NUM_CORES];
    logic [31:0]          base_q [NUM_CORES];
    logic [31:0]          base_d [NUM_CORES];
    logic                 res_found_q, res_found_d;
    logic [31:0]          res_nonce_q, res_nonce_d;

    logic [NUM_CORES-1:0] qual, bad;
    logic                 win_any, free_any, disp_en;
    logic [31:0]          win_nonce, disp_base;
    logic [32:0]          disp_rem, disp_take;
    int unsigned          free_idx, disp_idx;

    // A found counts once the core is past its two blanking cycles (budget <= CHUNK_CYCLES-2).
    always_comb begin
        qual      = '0;
        bad       = '0;
        win_any   = 1'b0;
        win_nonce = '0;
        free_any  = 1'b0;
        free_idx  = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (active_q[i] && core_found_i[i] && (budget_q[i] <= BLANK_LIMIT)) begin
                if ((core_nonce_i[i*32 +: 32] - start_q) < count_q) qual[i] = 1'b1;
                else                                                  bad[i]  = 1'b1;
            end
            if (qual[i] && !win_any) begin
                win_any   = 1'b1;
                win_nonce = core_nonce_i[i*32 +: 32];
            end
            if (!active_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        count_d       = count_q;
        next_base_d   = next_base_q;
        remaining_d   = remaining_q;
        active_d      = active_q;
        start_pulse_d = '0;
        budget_d      = budget_q;
        base_d        = base_q;
        res_found_d   = res_found_q;
        res_nonce_d   = res_nonce_q;
        disp_en       = 1'b0;
        disp_idx      = 0;
        disp_base     = next_base_q;
        disp_rem      = remaining_q;
        disp_take     = '0;

        case (state_q)
            S_IDLE: begin
                // Core 0 is dispatched straight from the accept so its pulse lands on T+1.
                if (job_valid_i) begin
                    start_d     = job_nonce_start_i;
                    count_d     = job_nonce_count_i;
                    next_base_d = job_nonce_start_i;
                    remaining_d = {1'b0, job_nonce_count_i};
                    active_d    = '0;
                    state_d     = S_RUN;
                    disp_base   = job_nonce_start_i;
                    disp_rem    = {1'b0, job_nonce_count_i};
                    disp_en     = (job_nonce_count_i != '0);
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d  = S_IDLE;
                    active_d = '0;
                end else if (win_any) begin
                    state_d     = S_DONE;
                    active_d    = '0;
                    res_found_d = 1'b1;
                    res_nonce_d = win_nonce;
                end else if (remaining_q == '0 && active_q == '0) begin
                    state_d     = S_DONE;
                    res_found_d = 1'b0;
                    res_nonce_d = '0;
                end else begin
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (active_q[i]) begin
                            budget_d[i] = budget_q[i] - budget_t'(1);
                            if (budget_q[i] == budget_t'(1) || bad[i]) active_d[i] = 1'b0;
                        end
                    end
                    disp_en  = free_any && (remaining_q != '0);
                    disp_idx = free_idx;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                active_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (disp_en) begin
            disp_take   = (disp_rem > CHUNK33) ? CHUNK33 : disp_rem;
            next_base_d = disp_base + CHUNK32;
            remaining_d = disp_rem - disp_take;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (i == disp_idx) begin
                    start_pulse_d[i] = 1'b1;
                    base_d[i]        = disp_base;
                    budget_d[i]      = BUDGET_FULL;
                    active_d[i]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            start_q       <= '0;
            count_q       <= '0;
            next_base_q   <= '0;
            remaining_q   <= '0;
            active_q      <= '0;
            start_pulse_q <= '0;
            res_found_q   <= 1'b0;
            res_nonce_q   <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                budget_q[i] <= '0;
                base_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            count_q       <= count_d;
            next_base_q   <= next_base_d;
            remaining_q   <= remaining_d;
            active_q      <= active_d;
            start_pulse_q <= start_pulse_d;
            res_found_q   <= res_found_d;
            res_nonce_q   <= res_nonce_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                budget_q[i] <= budget_d[i];
                base_q[i]   <= base_d[i];
            end
        end
    end

    always_comb begin
        core_nonce_base_o = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) core_nonce_base_o[i*32 +: 32] = base_q[i];
    end

    assign job_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign core_start_o = start_pulse_q;
    assign res_valid_o  = (state_q == S_DONE) && !abort_i;
    assign res_found_o  = res_found_q;
    assign res_nonce_o  = res_nonce_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Self-checking bench for sha256_nonce_sched against a timestamp-based scheduling model.
module tb_sha256_nonce_sched;

    localparam int NC   = 4;
    localparam int CH   = 16;
    localparam int CC   = 8;
    localparam int MAXD = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [31:0]       job_nonce_start;
    logic [31:0]       job_nonce_count;
    logic              abort;
    logic [NC-1:0]     core_start;
    logic [NC*32-1:0]  core_nonce_base;
    logic [NC-1:0]     core_found;
    logic [NC*32-1:0]  core_nonce;
    logic              res_valid;
    logic              res_found;
    logic [31:0]       res_nonce;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [NC-1:0] fmask     [0:MAXD];
    logic [31:0]   fnon      [0:MAXD][0:NC-1];
    logic [NC-1:0] exp_start [0:MAXD];
    logic [31:0]   exp_base  [0:MAXD];
    int            res_t;
    logic          res_f;
    logic [31:0]   res_n;

    sha256_nonce_sched #(.NUM_CORES(NC), .CHUNK(CH), .CHUNK_CYCLES(CC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_nonce_start_i(job_nonce_start), .job_nonce_count_i(job_nonce_count),
        .abort_i(abort),
        .core_start_o(core_start), .core_nonce_base_o(core_nonce_base),
        .core_found_i(core_found), .core_nonce_i(core_nonce),
        .res_valid_o(res_valid), .res_found_o(res_found), .res_nonce_o(res_nonce),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_founds();
        for (int d = 0; d <= MAXD; d++) begin
            fmask[d] = '0;
            for (int c = 0; c < NC; c++) fnon[d][c] = '0;
        end
    endtask

    task automatic add_found(input int d, input int c, input logic [31:0] n);
        fmask[d][c] = 1'b1;
        fnon[d][c]  = n;
    endtask

    // Model: cores are tracked by pulse time and first inactive cycle; d is the decision cycle after accept.
    task automatic model_job(input logic [31:0] st, input logic [31:0] cnt);
        int          inact [NC];
        int          pulse [NC];
        logic [32:0] rem;
        logic [32:0] ch33;
        logic [31:0] nb;
        bit          done;
        bit          all_idle;
        int          win;
        int          sel;
        ch33 = 33'(CH);
        rem  = {1'b0, cnt};
        nb   = st;
        done = 0;
        res_t = -1;
        res_f = 1'b0;
        res_n = '0;
        for (int c = 0; c < NC; c++) begin
            inact[c] = 0;
            pulse[c] = -100;
        end
        for (int d = 0; d <= MAXD; d++) begin
            exp_start[d] = '0;
            exp_base[d]  = '0;
        end
        for (int d = 0; d < MAXD && !done; d++) begin
            if (d >= 1) begin
                win = -1;
                for (int c = NC - 1; c >= 0; c--)
                    if (fmask[d][c] && d >= pulse[c] + 2 && d < inact[c] && (fnon[d][c] - st) < cnt)
                        win = c;
                if (win >= 0) begin
                    done  = 1;
                    res_t = d + 1;
                    res_f = 1'b1;
                    res_n = fnon[d][win];
                end else begin
                    for (int c = 0; c < NC; c++)
                        if (fmask[d][c] && d >= pulse[c] + 2 && d < inact[c]) inact[c] = d + 1;
                    all_idle = 1;
                    for (int c = 0; c < NC; c++) if (inact[c] > d) all_idle = 0;
                    if (rem == '0 && all_idle) begin
                        done  = 1;
                        res_t = d + 1;
                    end
                end
            end
            if (!done && rem != '0) begin
                sel = -1;
                for (int c = NC - 1; c >= 0; c--) if (inact[c] <= d) sel = c;
                if (sel >= 0) begin
                    exp_start[d+1][sel] = 1'b1;
                    exp_base[d+1]       = nb;
                    pulse[sel]          = d + 1;
                    inact[sel]          = d + 1 + CC;
                    nb                  = nb + 32'(CH);
                    rem                 = rem - ((rem > ch33) ? ch33 : rem);
                end
            end
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] st, input logic [31:0] cnt);
        model_job(st, cnt);
        checks++;
        if (res_t < 0) begin
            errors++;
            $display("FAIL %s model_budget: no result within %0d cycles", name, MAXD);
            return;
        end
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, job_ready);
        end
        job_valid       = 1'b1;
        job_nonce_start = st;
        job_nonce_count = cnt;
        core_found      = '0;
        for (int d = 1; d <= res_t; d++) begin
            @(negedge clk);
            checks++;
            if (core_start !== exp_start[d]) begin
                errors++;
                $display("FAIL %s core_start@%0d: got %b want %b", name, d, core_start, exp_start[d]);
            end
            for (int c = 0; c < NC; c++) begin
                if (exp_start[d][c]) begin
                    checks++;
                    if (core_nonce_base[c*32 +: 32] !== exp_base[d]) begin
                        errors++;
                        $display("FAIL %s base%0d@%0d: got %h want %h", name, c, d,
                                 core_nonce_base[c*32 +: 32], exp_base[d]);
                    end
                end
            end
            checks++;
            if (res_valid !== 1'(d == res_t)) begin
                errors++;
                $display("FAIL %s res_valid@%0d: got %b want %b", name, d, res_valid, d == res_t);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy@%0d: got %b want 1", name, d, busy);
            end
            if (d == res_t) begin
                checks++;
                if (res_found !== res_f) begin
                    errors++;
                    $display("FAIL %s res_found: got %b want %b", name, res_found, res_f);
                end
                checks++;
                if (res_nonce !== res_n) begin
                    errors++;
                    $display("FAIL %s res_nonce: got %h want %h", name, res_nonce, res_n);
                end
            end
            job_valid  = 1'b0;
            core_found = fmask[d];
            for (int c = 0; c < NC; c++)
                core_nonce[c*32 +: 32] = fmask[d][c] ? fnon[d][c] : $urandom;
        end
        @(negedge clk);
        core_found = '0;
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: ready=%b busy=%b res_valid=%b want 1/0/0",
                     name, job_ready, busy, res_valid);
        end
        checks++;
        if (res_found !== res_f || res_nonce !== res_n) begin
            errors++;
            $display("FAIL %s result_hold: got %b/%h want %b/%h", name, res_found, res_nonce, res_f, res_n);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || core_start !== '0 || core_nonce_base !== '0 ||
            res_valid !== 1'b0 || res_found !== 1'b0 || res_nonce !== '0) begin
            errors++;
            $display("FAIL %s: ready=%b busy=%b start=%b base=%h rv=%b rf=%b rn=%h want 1 0 0 0 0 0 0",
                     name, job_ready, busy, core_start, core_nonce_base, res_valid, res_found, res_nonce);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_no_found();
        clear_founds();
        run_job("no_found", 32'h100, 32'd64);
    endtask

    task automatic test_partial_chunks();
        clear_founds();
        run_job("partial", 32'h0, 32'd100);
    endtask

    task automatic test_multi_found();
        clear_founds();
        add_found(6, 1, 32'h15);
        add_found(6, 3, 32'h31);
        run_job("multi_found", 32'h0, 32'd64);
    endtask

    task automatic test_wrap();
        clear_founds();
        add_found(5, 0, 32'h3);
        run_job("wrap", 32'hFFFF_FFF8, 32'd32);
    endtask

    task automatic test_out_of_range();
        clear_founds();
        add_found(4, 1, 32'h1F);
        run_job("out_of_range", 32'h0, 32'd20);
    endtask

    task automatic test_blanking();
        clear_founds();
        add_found(1, 0, 32'h2005);
        add_found(3, 1, 32'h2014);
        add_found(4, 1, 32'h2013);
        run_job("blanking", 32'h2000, 32'd64);
    endtask

    task automatic test_count_zero();
        clear_founds();
        run_job("count_zero", 32'h1234, 32'd0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        job_valid       = 1'b1;
        job_nonce_start = 32'h700;
        job_nonce_count = 32'd64;
        @(negedge clk);
        job_valid = 1'b0;
        checks++;
        if (core_start !== 4'b0001) begin
            errors++;
            $display("FAIL abort_first_pulse: got %b want 0001", core_start);
        end
        abort = 1'b1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_res_valid_run: got %b want 0", res_valid);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || core_start !== '0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b busy=%b start=%b want 1 0 0", job_ready, busy, core_start);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || core_start !== '0) begin
                errors++;
                $display("FAIL abort_quiet@%0d: res_valid=%b start=%b want 0 0", i, res_valid, core_start);
            end
        end
        clear_founds();
        run_job("after_abort", 32'h5000, 32'd32);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        job_valid       = 1'b1;
        job_nonce_start = 32'h9000;
        job_nonce_count = 32'd80;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || core_start !== '0) begin
                errors++;
                $display("FAIL reset_quiet@%0d: res_valid=%b start=%b want 0 0", i, res_valid, core_start);
            end
        end
        clear_founds();
        add_found(7, 2, 32'h3021);
        run_job("after_reset", 32'h3000, 32'd48);
    endtask

    task automatic test_back_to_back();
        clear_founds();
        add_found(3, 0, 32'hABC4);
        run_job("b2b_a", 32'hABC0, 32'd40);
        clear_founds();
        run_job("b2b_b", 32'h10, 32'd17);
    endtask

    task automatic test_random();
        logic [31:0] st;
        logic [31:0] cnt;
        int          nev;
        for (int j = 0; j < 16; j++) begin
            st  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            cnt = 32'($urandom_range(0, 120));
            clear_founds();
            nev = $urandom_range(0, 3);
            for (int e = 0; e < nev; e++)
                add_found($urandom_range(1, 25), $urandom_range(0, NC - 1),
                          st + 32'($urandom_range(0, cnt + 24)));
            run_job($sformatf("random%0d", j), st, cnt);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        job_valid       = 1'b0;
        job_nonce_start = '0;
        job_nonce_count = '0;
        abort           = 1'b0;
        core_found      = '0;
        core_nonce      = '0;
        test_reset();
        test_no_found();
        test_partial_chunks();
        test_multi_found();
        test_wrap();
        test_out_of_range();
        test_blanking();
        test_count_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
